seq_chk: RTL
============

SEQ_CHK -- requirements
Module: seq_chk

Interface
REQ-001 Parameter LOCK_FRAMES, default 2, SHALL be the number of consecutive good frames in CHECK required to enter LOCKED (range 1..15).
REQ-002 Parameter MISS_MAX, default 3, SHALL be the number of consecutive mismatches in LOCKED that drops lock (range 1..15).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 seq_in  input  8  SHALL be the received symbol: frame 0x01, 0x02, 0x04, 0x08, repeating.
REQ-006 in_vld  input  1  SHALL qualify seq_in; beats with in_vld=0 are ignored.
REQ-007 cnt_clr  input  1  SHALL synchronously clear err_cnt and frame_cnt.
REQ-008 locked  output  1  SHALL be high while in LOCKED.
REQ-009 frame_done  output  1  SHALL pulse for one cycle per completed in-order frame.
REQ-010 err_pulse  output  1  SHALL pulse for one cycle per mismatch counted in LOCKED.
REQ-011 err_cnt  output  8  SHALL be the saturating count of err_pulse events.
REQ-012 frame_cnt  output  16  SHALL be the wrapping count of frame_done events.
REQ-013 state  output  2  SHALL expose the FSM state (HUNT=0, CHECK=1, LOCKED=2).

Function
REQ-014 Expected symbol SHALL be 1<<exp_idx, exp_idx a 2-bit index wrapping 3->0.
REQ-015 All outputs SHALL be registered and reflect a sampled beat on the edge that samples it (one-cycle latency); with in_vld=0, FSM, exp_idx and run counters hold and pulses are 0.
REQ-016 HUNT: seq_in==0x01 -> CHECK, exp_idx=1, good_run=0; any other value (including 0x00) -> stay, no error.
REQ-017 CHECK match: exp_idx advances; on 0x08 pulse frame_done, good_run+1; when good_run reaches LOCK_FRAMES -> LOCKED, miss_run=0.
REQ-018 CHECK mismatch: if seq_in==0x01 restart CHECK with exp_idx=1, good_run=0; otherwise -> HUNT; no err_pulse.
REQ-019 LOCKED match: exp_idx advances, miss_run=0; on 0x08 pulse frame_done.
REQ-020 LOCKED mismatch: err_pulse, err_cnt+1, miss_run+1, exp_idx still advances (flywheel); when miss_run reaches MISS_MAX -> HUNT, locked=0 on that edge.
REQ-021 err_cnt SHALL saturate at 255; frame_cnt SHALL wrap 65535->0.
REQ-022 cnt_clr together with an increment SHALL leave the counter at 0 (clear wins); pulses still fire.
REQ-023 A mismatch on the 0x08 position SHALL NOT pulse frame_done.

Reset
REQ-024 reset low SHALL immediately force state=HUNT, exp_idx=0, good_run=0, miss_run=0, locked=0, frame_done=0, err_pulse=0, err_cnt=0, frame_cnt=0, regardless of clk.
REQ-025 Reset asserted mid-frame SHALL discard the partial frame; after release the block hunts for 0x01.

Structure
REQ-026 Shared package seq_pkg SHALL hold state encodings, symbol constants SYM0..SYM3 (0x01..0x08) and SEQ_LEN=4, shared with the generator.
REQ-027 Saturating counter SHALL be sub-module seq_sat_cnt (parameter WIDTH, inputs inc/clr); frame_cnt is an inline wrapping counter.

Verification
REQ-028 in_vld=1, stream 01,02,04,08,01,02,04,08 -> frame_done on both 0x08 beats, locked=1 after second, frame_cnt=2, err_cnt=0.
REQ-029 Locked, replace one 0x04 with 0x10 -> one err_pulse, err_cnt=1, locked stays 1, following 0x08 gives frame_done.
REQ-030 Locked, three consecutive wrong symbols -> three err_pulse, err_cnt=3, locked=0, state=HUNT after third; then 0x01 -> CHECK.
REQ-031 CHECK, stream 01,02,01,02,04,08 -> second 0x01 restarts CHECK, no err_pulse, one frame_done.
REQ-032 Locked stream with in_vld low on random cycles (seq_in garbage) -> behaviour identical to gap-free stream.
REQ-033 reset low asynchronously mid-LOCKED -> all outputs 0 before next clk edge; cnt_clr with coincident err_pulse -> err_cnt=0.

Source files
------------

// File: rtl/seq_pkg.sv
// seq_pkg: state encodings and frame symbols
// shared by the checker and the stream generator.
package seq_pkg;

    localparam logic [1:0] ST_HUNT   = 2'd0;
    localparam logic [1:0] ST_CHECK  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam logic [7:0] SYM0 = 8'h01;
    localparam logic [7:0] SYM1 = 8'h02;
    localparam logic [7:0] SYM2 = 8'h04;
    localparam logic [7:0] SYM3 = 8'h08;

    localparam int SEQ_LEN = 4;

    function automatic logic [7:0] sym_of(input logic [1:0] idx);
        sym_of = SYM0 << idx;
    endfunction

endpackage

// File: rtl/seq_chk_if.sv
// seq_chk_if: symbol stream in, lock status
// and counters out.
interface seq_chk_if;
    import seq_pkg::*;

    logic [7:0]  seq_in;
    logic        in_vld;
    logic        cnt_clr;
    logic        locked;
    logic        frame_done;
    logic        err_pulse;
    logic [7:0]  err_cnt;
    logic [15:0] frame_cnt;
    logic [1:0]  state;

    modport master (
        output seq_in, in_vld, cnt_clr,
        input  locked, frame_done, err_pulse,
        input  err_cnt, frame_cnt, state
    );

    modport slave (
        input  seq_in, in_vld, cnt_clr,
        output locked, frame_done, err_pulse,
        output err_cnt, frame_cnt, state
    );

endinterface

// File: rtl/seq_sat_cnt.sv
// seq_sat_cnt: up counter that sticks at all-ones;
// a clear on the same cycle as inc wins.
module seq_sat_cnt #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] cnt
);

    // count up, hold at max, clear has priority
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && (cnt != {WIDTH{1'b1}}))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/seq_chk.sv
// seq_chk: frame sync checker for the 01,02,04,08
// symbol stream with hunt/check/locked flywheel.
module seq_chk
    import seq_pkg::*;
#(
    parameter int LOCK_FRAMES = 2,
    parameter int MISS_MAX    = 3
) (
    input logic      clk,
    input logic      reset,
    seq_chk_if.slave bus
);

    localparam logic [3:0] LOCK_W = 4'(LOCK_FRAMES);
    localparam logic [3:0] MISS_W = 4'(MISS_MAX);

    logic [1:0]  st, st_n;
    logic [1:0]  idx, idx_n;
    logic [3:0]  good, good_n;
    logic [3:0]  miss, miss_n;
    logic        fd, fd_n;
    logic        ep, ep_n;
    logic [15:0] fcnt;
    logic [7:0]  ecnt;
    logic        match;
    logic        last;
    logic [3:0]  good_inc;
    logic [3:0]  miss_inc;

    assign match    = (bus.seq_in == sym_of(idx));
    assign last     = (idx == 2'(SEQ_LEN - 1));
    assign good_inc = good + 4'd1;
    assign miss_inc = miss + 4'd1;

    // next-state and pulse decode for one sampled beat
    always_comb begin
        st_n   = st;
        idx_n  = idx;
        good_n = good;
        miss_n = miss;
        fd_n   = 1'b0;
        ep_n   = 1'b0;
        if (bus.in_vld) begin
            unique case (1'b1)
                (st == ST_CHECK): begin
                    if (match) begin
                        idx_n = idx + 2'd1;
                        if (last) begin
                            fd_n   = 1'b1;
                            good_n = good_inc;
                            if (good_inc == LOCK_W) begin
                                st_n   = ST_LOCKED;
                                miss_n = 4'd0;
                            end
                        end
                    end else if (bus.seq_in == SYM0) begin
                        idx_n  = 2'd1;
                        good_n = 4'd0;
                    end else begin
                        st_n  = ST_HUNT;
                        idx_n = 2'd0;
                    end
                end
                (st == ST_LOCKED): begin
                    idx_n = idx + 2'd1;
                    if (match) begin
                        miss_n = 4'd0;
                        fd_n   = last;
                    end else begin
                        ep_n   = 1'b1;
                        miss_n = miss_inc;
                        if (miss_inc == MISS_W) begin
                            st_n  = ST_HUNT;
                            idx_n = 2'd0;
                        end
                    end
                end
                default: begin
                    st_n  = ST_HUNT;
                    idx_n = 2'd0;
                    if (bus.seq_in == SYM0) begin
                        st_n   = ST_CHECK;
                        idx_n  = 2'd1;
                        good_n = 4'd0;
                    end
                end
            endcase
        end
    end

    // FSM, run counters and output pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st   <= ST_HUNT;
            idx  <= 2'd0;
            good <= 4'd0;
            miss <= 4'd0;
            fd   <= 1'b0;
            ep   <= 1'b0;
        end else begin
            st   <= st_n;
            idx  <= idx_n;
            good <= good_n;
            miss <= miss_n;
            fd   <= fd_n;
            ep   <= ep_n;
        end
    end

    // wrapping frame counter, clear wins
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            fcnt <= 16'd0;
        else if (bus.cnt_clr)
            fcnt <= 16'd0;
        else if (fd_n)
            fcnt <= fcnt + 16'd1;
    end

    seq_sat_cnt #(
        .WIDTH (8)
    ) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (ep_n),
        .clr   (bus.cnt_clr),
        .cnt   (ecnt)
    );

    assign bus.state      = st;
    assign bus.locked     = (st == ST_LOCKED);
    assign bus.frame_done = fd;
    assign bus.err_pulse  = ep;
    assign bus.err_cnt    = ecnt;
    assign bus.frame_cnt  = fcnt;

endmodule
